instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 48 ++++
 rtl/instr_encoder_if.sv | 28 ++
 rtl/instr_encoder_pack.sv | 34 +++
 rtl/instr_encoder.sv | 82 ++++++++
 tb/tb_instr_encoder.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared encodings for the MIPS instruction encoder: request kinds,
// opcodes, R-type funct codes and the session FSM states.
package instr_encoder_pkg;

  typedef enum logic [3:0] {
    K_ADD  = 4'd0,
    K_SUB  = 4'd1,
    K_AND  = 4'd2,
    K_OR   = 4'd3,
    K_SLT  = 4'd4,
    K_LW   = 4'd5,
    K_SW   = 4'd6,
    K_BEQ  = 4'd7,
    K_ADDI = 4'd8,
    K_J    = 4'd9
  } kind_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Session control, request handshake and instruction-memory write bus.
interface instr_encoder_if #(parameter int ADDR_W = 8);
  logic              Start;
  logic [ADDR_W-1:0] BaseAddr;
  logic [ADDR_W-1:0] Count;
  logic              ReqValid;
  logic              ReqReady;
  logic [3:0]        ReqKind;
  logic [4:0]        Rs, Rt, Rd;
  logic [15:0]       Imm;
  logic [25:0]       Target;
  logic              ImemWE;
  logic [ADDR_W-1:0] ImemAddr;
  logic [31:0]       ImemWData;
  logic              Busy;
  logic              Done;
  logic              Err;

  modport master (
    output Start, BaseAddr, Count, ReqValid, ReqKind, Rs, Rt, Rd, Imm, Target,
    input  ReqReady, ImemWE, ImemAddr, ImemWData, Busy, Done, Err
  );

  modport slave (
    input  Start, BaseAddr, Count, ReqValid, ReqKind, Rs, Rt, Rd, Imm, Target,
    output ReqReady, ImemWE, ImemAddr, ImemWData, Busy, Done, Err
  );
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational packer: request fields to a 32-bit MIPS word.
// Illegal kinds produce a NOP and raise o_illegal.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  i_kind,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  always_comb begin
    o_word    = 32'h0000_0000;
    o_illegal = 1'b0;
    case (i_kind)
      K_ADD:   o_word = rtype(i_rs, i_rt, i_rd, FN_ADD);
      K_SUB:   o_word = rtype(i_rs, i_rt, i_rd, FN_SUB);
      K_AND:   o_word = rtype(i_rs, i_rt, i_rd, FN_AND);
      K_OR:    o_word = rtype(i_rs, i_rt, i_rd, FN_OR);
      K_SLT:   o_word = rtype(i_rs, i_rt, i_rd, FN_SLT);
      K_LW:    o_word = itype(OP_LW,   i_rs, i_rt, i_imm);
      K_SW:    o_word = itype(OP_SW,   i_rs, i_rt, i_imm);
      K_BEQ:   o_word = itype(OP_BEQ,  i_rs, i_rt, i_imm);
      K_ADDI:  o_word = itype(OP_ADDI, i_rs, i_rt, i_imm);
      K_J:     o_word = {OP_J, i_target};
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Load-session FSM: accepts encoded requests and writes them to
// consecutive instruction-memory words, one per two cycles.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  instr_encoder_if.slave   bus
);

  state_e            r_state, w_next;
  logic [ADDR_W-1:0] r_addr, r_waddr, r_remaining;
  logic [31:0]       r_data;
  logic              r_err;
  logic [31:0]       w_word;
  logic              w_illegal;

  instr_pack u_pack (
    .i_kind    (bus.ReqKind),
    .i_rs      (bus.Rs),
    .i_rt      (bus.Rt),
    .i_rd      (bus.Rd),
    .i_imm     (bus.Imm),
    .i_target  (bus.Target),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.Start) w_next = (bus.Count != '0) ? S_ACCEPT : S_DONE;
      S_ACCEPT: if (bus.ReqValid) w_next = S_WRITE;
      S_WRITE:  w_next = (r_remaining == ADDR_W'(1)) ? S_DONE : S_ACCEPT;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_waddr     <= '0;
      r_remaining <= '0;
      r_data      <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (bus.Start) begin
          r_addr      <= bus.BaseAddr;
          r_remaining <= bus.Count;
          r_err       <= 1'b0;
        end
        // The write address is captured with the word so ImemAddr holds
        // the last written location once the session moves on.
        S_ACCEPT: if (bus.ReqValid) begin
          r_data  <= w_word;
          r_waddr <= r_addr;
          if (w_illegal) r_err <= 1'b1;
        end
        S_WRITE: begin
          r_addr      <= r_addr + ADDR_W'(1);
          r_remaining <= r_remaining - ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.ReqReady  = (r_state == S_ACCEPT);
  assign bus.ImemWE    = (r_state == S_WRITE);
  assign bus.ImemAddr  = r_waddr;
  assign bus.ImemWData = r_data;
  assign bus.Busy      = (r_state != S_IDLE);
  assign bus.Done      = (r_state == S_DONE);
  assign bus.Err       = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed encodings, address wrap,
// illegal kinds, zero-count sessions and mid-session reset.
module tb_instr_encoder;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] base, input logic [7:0] cnt);
    @(negedge clk);
    bus.Start = 1'b1; bus.BaseAddr = base; bus.Count = cnt;
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  // Waits for ReqReady, presents one request, checks the write one cycle later.
  task automatic send(input string tag, input logic [3:0] kind, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic [7:0] exp_addr,
                      input logic [31:0] exp_data);
    int n = 0;
    while (bus.ReqReady !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_ready"}, {31'd0, bus.ReqReady}, 32'd1);
    bus.ReqValid = 1'b1; bus.ReqKind = kind;
    bus.Rs = rs; bus.Rt = rt; bus.Rd = rd; bus.Imm = imm; bus.Target = tgt;
    @(negedge clk);
    bus.ReqValid = 1'b0;
    chk({tag, "_we"},   {31'd0, bus.ImemWE}, 32'd1);
    chk({tag, "_addr"}, {24'd0, bus.ImemAddr}, {24'd0, exp_addr});
    chk({tag, "_data"}, bus.ImemWData, exp_data);
  endtask

  task automatic expect_done(input string tag);
    @(negedge clk);
    chk({tag, "_done"}, {31'd0, bus.Done}, 32'd1);
    chk({tag, "_we_off"}, {31'd0, bus.ImemWE}, 32'd0);
    @(negedge clk);
    chk({tag, "_idle"}, {30'd0, bus.Done, bus.Busy}, 32'd0);
  endtask

  initial begin
    int dn, wn, rn;
    bus.Start = 0; bus.BaseAddr = 0; bus.Count = 0; bus.ReqValid = 0;
    bus.ReqKind = 0; bus.Rs = 0; bus.Rt = 0; bus.Rd = 0; bus.Imm = 0; bus.Target = 0;
    #12;
    chk("rst_outs", {bus.ReqReady, bus.ImemWE, bus.Busy, bus.Done, bus.Err}, 32'd0);
    chk("rst_addr_data", {bus.ImemWData[23:0], bus.ImemAddr}, 32'd0);
    rst_n = 1'b1;

    // Single ADD
    start(8'h10, 8'd1);
    chk("s1_busy", {31'd0, bus.Busy}, 32'd1);
    send("add", 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 8'h10, 32'h0022_1820);
    expect_done("s1");
    chk("s1_hold_addr", {24'd0, bus.ImemAddr}, 32'h10);
    chk("s1_hold_data", bus.ImemWData, 32'h0022_1820);

    // LW / BEQ / J
    start(8'h20, 8'd3);
    send("lw",  4'd5, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 8'h20, 32'h8FA8_0004);
    send("beq", 4'd7, 5'd1,  5'd2, 5'd0, 16'hFFFF, 26'h0, 8'h21, 32'h1022_FFFF);
    send("j",   4'd9, 5'd7,  5'd7, 5'd7, 16'h1234, 26'h10, 8'h22, 32'h0800_0010);
    expect_done("s2");

    // R-type funct codes and SW
    start(8'h30, 8'd4);
    send("sub", 4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 8'h30, 32'h0085_3022);
    send("and", 4'd2, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 8'h31, 32'h0085_3024);
    send("or",  4'd3, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 8'h32, 32'h0085_3025);
    send("sw",  4'd6, 5'd29, 5'd9, 5'd0, 16'h0008, 26'h0, 8'h33, 32'hAFA9_0008);
    expect_done("s3");

    // Address wrap
    start(8'hFF, 8'd2);
    send("addi_a", 4'd8, 5'd0, 5'd2, 5'd0, 16'h0005, 26'h0, 8'hFF, 32'h2002_0005);
    send("addi_b", 4'd8, 5'd0, 5'd2, 5'd0, 16'h0005, 26'h0, 8'h00, 32'h2002_0005);
    expect_done("wrap");
    chk("wrap_err", {31'd0, bus.Err}, 32'd0);

    // Illegal kind writes NOP and sets sticky Err
    start(8'h40, 8'd2);
    send("ill", 4'd12, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h3FF_FFFF, 8'h40, 32'h0);
    chk("ill_err", {31'd0, bus.Err}, 32'd1);
    send("slt", 4'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 8'h41, 32'h0022_182A);
    expect_done("ill");
    chk("ill_err_sticky", {31'd0, bus.Err}, 32'd1);

    // Zero-count session: one Done pulse, no write, Err cleared
    start(8'h50, 8'd0);
    chk("z_err_clr", {31'd0, bus.Err}, 32'd0);
    dn = 0; wn = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.Done === 1'b1) dn++;
      if (bus.ImemWE === 1'b1) wn++;
      @(negedge clk);
    end
    chk("z_done_cnt", dn, 32'd1);
    chk("z_we_cnt", wn, 32'd0);

    // Reset in the middle of a session
    start(8'h60, 8'd3);
    send("rst_a", 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 8'h60, 32'h0022_1820);
    bus.ReqValid = 1'b1; bus.ReqKind = 4'd12;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {bus.ReqReady, bus.ImemWE, bus.Busy, bus.Done, bus.Err}, 32'd0);
    chk("mid_rst_addr", {24'd0, bus.ImemAddr}, 32'd0);
    chk("mid_rst_data", bus.ImemWData, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wn = 0; rn = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.ImemWE === 1'b1) wn++;
      if (bus.ReqReady === 1'b1) rn++;
    end
    bus.ReqValid = 1'b0;
    chk("post_rst_we", wn, 32'd0);
    chk("post_rst_ready", rn, 32'd0);
    chk("post_rst_err", {31'd0, bus.Err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
